burst_data_memory: RTL and testbench

Parametrised single-port data memory with a valid/ready request port, programmable read wait states and multi-word burst reads.
It replaces the fixed 1024x16 combinational-read data memory in the datapath.
It serves load/store and block-copy traffic from the controller.
Writes are single-word; reads return 1..MAX_BURST consecutive words as a registered stream.

---
 rtl/burst_data_memory.sv | 154 +++++++++++++++
 tb/tb_burst_data_memory.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/burst_data_memory.sv
// Single-port data memory with a valid/ready request port, programmable
// read wait states and multi-word burst reads returned as a registered stream.
module burst_data_memory #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int WAIT_CYC  = 1,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 5,
    parameter int INIT_BASE = 100,
    parameter int INIT_LEN  = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_adr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [LEN_W-1:0]  req_len_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYC);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
    typedef logic [DATA_W-1:0] memArray_t [DEPTH];

    // Power-up image: a short ascending sequence 1..INIT_LEN at INIT_BASE.
    function automatic memArray_t initMem();
        memArray_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = '0;
        end
        for (int i = 0; i < INIT_LEN; i++) begin
            m[ADDR_W'(INIT_BASE + i)] = DATA_W'(i + 1);
        end
        return m;
    endfunction

    memArray_t mem_q = initMem();

    state_t            state_q, state_d;
    logic [2:0]        waitCnt_q, waitCnt_d;
    logic [ADDR_W-1:0] curAdr_q, curAdr_d;
    logic [LEN_W-1:0]  beatsLeft_q, beatsLeft_d;
    logic              rdValid_q, rdValid_d;
    logic              rdLast_q, rdLast_d;
    logic [DATA_W-1:0] rdData_q, rdData_d;
    logic              err_q, err_d;
    logic              memWe;
    logic              lenOk;

    assign lenOk = (req_len_i != '0) && (req_len_i <= MAX_LEN);

    // Memory array is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            mem_q[req_adr_i] <= req_wdata_i;
        end
    end

    // Control and read-stream registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            waitCnt_q   <= '0;
            curAdr_q    <= '0;
            beatsLeft_q <= '0;
            rdValid_q   <= 1'b0;
            rdLast_q    <= 1'b0;
            rdData_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            waitCnt_q   <= waitCnt_d;
            curAdr_q    <= curAdr_d;
            beatsLeft_q <= beatsLeft_d;
            rdValid_q   <= rdValid_d;
            rdLast_q    <= rdLast_d;
            rdData_q    <= rdData_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: accept requests in IDLE, count wait states, then
    // stream one beat per cycle; an extra BURST cycle with no beats left
    // clears the stream flags before returning to IDLE.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        curAdr_d    = curAdr_q;
        beatsLeft_d = beatsLeft_q;
        rdValid_d   = 1'b0;
        rdLast_d    = 1'b0;
        rdData_d    = rdData_q;
        err_d       = 1'b0;
        memWe       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_we_i) begin
                        memWe = 1'b1;
                    end else if (lenOk) begin
                        curAdr_d    = req_adr_i;
                        beatsLeft_d = req_len_i;
                        if (WAIT_CYC > 0) begin
                            state_d   = WAIT;
                            waitCnt_d = WAIT_INIT;
                        end else begin
                            state_d = BURST;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                waitCnt_d = waitCnt_q - 3'd1;
                if (waitCnt_q <= 3'd1) begin
                    waitCnt_d = '0;
                    state_d   = BURST;
                end
            end
            BURST: begin
                if (beatsLeft_q != '0) begin
                    rdValid_d   = 1'b1;
                    rdData_d    = mem_q[curAdr_q];
                    rdLast_d    = (beatsLeft_q == LEN_W'(1));
                    curAdr_d    = curAdr_q + 1'b1;
                    beatsLeft_d = beatsLeft_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = ~req_ready_o;
    assign rd_valid_o  = rdValid_q;
    assign rd_last_o   = rdLast_q;
    assign rd_data_o   = rdData_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_burst_data_memory.sv
// Directed self-checking bench for burst_data_memory: one instance with one
// read wait state and one with none, sharing clock, reset and request fields.
module tb_burst_data_memory;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        reqValid0 = 1'b0;
    logic        reqValid1 = 1'b0;
    logic        reqWe = 1'b0;
    logic [9:0]  reqAdr = '0;
    logic [15:0] reqWdata = '0;
    logic [4:0]  reqLen = '0;

    logic        ready0, busy0, valid0, last0, err0;
    logic [15:0] data0;
    logic        ready1, busy1, valid1, last1, err1;
    logic [15:0] data1;

    int          sel = 0;
    logic        obsReady, obsBusy, obsValid, obsLast, obsErr;
    logic [15:0] obsData;

    int          compared = 0;
    int          mismatched = 0;
    int          acceptWr1 = 0;
    logic [15:0] expBeats [16];

    always #5 clk = ~clk;

    burst_data_memory #(.WAIT_CYC(1)) dut0 (
        .clk_i(clk), .rst_ni(rstN), .req_valid_i(reqValid0), .req_ready_o(ready0),
        .req_we_i(reqWe), .req_adr_i(reqAdr), .req_wdata_i(reqWdata), .req_len_i(reqLen),
        .rd_valid_o(valid0), .rd_data_o(data0), .rd_last_o(last0), .busy_o(busy0), .err_o(err0)
    );

    burst_data_memory #(.WAIT_CYC(0)) dut1 (
        .clk_i(clk), .rst_ni(rstN), .req_valid_i(reqValid1), .req_ready_o(ready1),
        .req_we_i(reqWe), .req_adr_i(reqAdr), .req_wdata_i(reqWdata), .req_len_i(reqLen),
        .rd_valid_o(valid1), .rd_data_o(data1), .rd_last_o(last1), .busy_o(busy1), .err_o(err1)
    );

    // Route the currently selected instance onto a common set of observed signals.
    always_comb begin
        if (sel == 0) begin
            obsReady = ready0; obsBusy = busy0; obsValid = valid0;
            obsLast = last0; obsErr = err0; obsData = data0;
        end else begin
            obsReady = ready1; obsBusy = busy1; obsValid = valid1;
            obsLast = last1; obsErr = err1; obsData = data1;
        end
    end

    // Count write handshakes on the zero-wait instance.
    always @(posedge clk) begin
        if (reqValid1 && reqWe && ready1) acceptWr1++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setValid(input logic v);
        if (sel == 0) reqValid0 = v;
        else reqValid1 = v;
    endtask

    // Present a request at a negedge, hold it until accepted, and return at
    // the negedge right after the accepting edge with req_valid dropped.
    task automatic applyStimulus(input logic we, input logic [9:0] adr, input logic [15:0] wdata, input logic [4:0] len);
        int budget = 0;
        bit done = 0;
        reqWe = we; reqAdr = adr; reqWdata = wdata; reqLen = len;
        setValid(1'b1);
        while (!done) begin
            if (obsReady) done = 1;
            @(posedge clk);
            if (!done) begin
                budget++;
                if (budget > 100) begin
                    checkOutput("acceptTimeout", 0, 1);
                    done = 1;
                end
                @(negedge clk);
            end
        end
        @(negedge clk);
        setValid(1'b0);
    endtask

    // Issue a read and check every cycle until the block is idle again.
    task automatic readBurst(input logic [9:0] adr, input logic [4:0] len, input int waitCyc, input string tag);
        applyStimulus(1'b0, adr, 16'h0, len);
        for (int k = 0; k <= waitCyc + len + 1; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= waitCyc) begin
                checkOutput({tag, ".waitValid"}, obsValid, 0);
                checkOutput({tag, ".waitReady"}, obsReady, 0);
            end else if (k <= waitCyc + len) begin
                checkOutput($sformatf("%s.data%0d", tag, k - waitCyc - 1), obsData, expBeats[k - waitCyc - 1]);
                checkOutput($sformatf("%s.valid%0d", tag, k - waitCyc - 1), obsValid, 1);
                checkOutput($sformatf("%s.last%0d", tag, k - waitCyc - 1), obsLast, (k == waitCyc + len) ? 1 : 0);
                checkOutput($sformatf("%s.ready%0d", tag, k - waitCyc - 1), obsReady, 0);
            end else begin
                checkOutput({tag, ".endValid"}, obsValid, 0);
                checkOutput({tag, ".endLast"}, obsLast, 0);
                checkOutput({tag, ".endReady"}, obsReady, 1);
                checkOutput({tag, ".endBusy"}, obsBusy, 0);
            end
        end
    endtask

    task automatic loadAscending(input int n);
        for (int i = 0; i < n; i++) expBeats[i] = 16'(i + 1);
    endtask

    // Hard stop in case the flow above ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        sel = 0;
        repeat (2) @(negedge clk);
        checkOutput("rst.valid", valid0, 0);
        checkOutput("rst.last", last0, 0);
        checkOutput("rst.data", data0, 0);
        checkOutput("rst.err", err0, 0);
        checkOutput("rst.valid1", valid1, 0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst.ready", ready0, 1);
        checkOutput("rst.busy", busy0, 0);

        loadAscending(10);
        readBurst(10'd100, 5'd10, 1, "rd100");

        applyStimulus(1'b1, 10'd5, 16'hBEEF, 5'd0);
        expBeats[0] = 16'hBEEF;
        readBurst(10'd5, 5'd1, 1, "rd5");

        applyStimulus(1'b1, 10'd1023, 16'h0011, 5'd0);
        applyStimulus(1'b1, 10'd0, 16'h0022, 5'd0);
        expBeats[0] = 16'h0011;
        expBeats[1] = 16'h0022;
        readBurst(10'd1023, 5'd2, 1, "wrap");

        applyStimulus(1'b0, 10'd100, 16'h0, 5'd0);
        checkOutput("len0.err", obsErr, 1);
        checkOutput("len0.valid", obsValid, 0);
        checkOutput("len0.ready", obsReady, 1);
        @(negedge clk);
        checkOutput("len0.errDrop", obsErr, 0);
        checkOutput("len0.valid2", obsValid, 0);
        applyStimulus(1'b0, 10'd100, 16'h0, 5'd17);
        checkOutput("len17.err", obsErr, 1);
        checkOutput("len17.valid", obsValid, 0);
        checkOutput("len17.ready", obsReady, 1);
        @(negedge clk);
        checkOutput("len17.errDrop", obsErr, 0);
        checkOutput("len17.valid2", obsValid, 0);

        applyStimulus(1'b0, 10'd100, 16'h0, 5'd10);
        repeat (4) @(negedge clk);
        checkOutput("abort.beat3", obsData, 16'd3);
        checkOutput("abort.valid3", obsValid, 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("abort.valid", obsValid, 0);
        checkOutput("abort.last", obsLast, 0);
        checkOutput("abort.data", obsData, 0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("abort.ready", obsReady, 1);
        loadAscending(10);
        readBurst(10'd100, 5'd10, 1, "reread");

        sel = 1;
        reqWe = 1'b0; reqAdr = 10'd100; reqLen = 5'd4;
        reqValid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("w0.c0valid", obsValid, 0);
        checkOutput("w0.c0ready", obsReady, 0);
        reqWe = 1'b1; reqAdr = 10'd200; reqWdata = 16'h5A5A;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("w0.data%0d", k), obsData, 16'(k));
            checkOutput($sformatf("w0.valid%0d", k), obsValid, 1);
            checkOutput($sformatf("w0.last%0d", k), obsLast, (k == 4) ? 1 : 0);
            checkOutput($sformatf("w0.ready%0d", k), obsReady, 0);
        end
        @(negedge clk);
        checkOutput("w0.endValid", obsValid, 0);
        checkOutput("w0.endReady", obsReady, 1);
        checkOutput("w0.noEarlyWrite", acceptWr1, 0);
        @(posedge clk);
        @(negedge clk);
        reqValid1 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("w0.writeOnce", acceptWr1, 1);
        expBeats[0] = 16'h5A5A;
        readBurst(10'd200, 5'd1, 0, "w0rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
